// File: rtl/ram_loader_ctrl.sv
// Loads a 16-byte program image into the SAP-1 RAM over a valid/ready byte stream, then hands the RAM to the CPU.
// Optional read-back checksum verify is compiled in when RAMCTL_VERIFY_EN is defined.
module ram_loader_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic [3:0] cpu_addr,
    input  logic       cpu_n_ce,
    input  logic [7:0] ram_dout,
    output logic [3:0] ram_addr,
    output logic [7:0] ram_din,
    output logic       ram_prog_mode,
    output logic       ram_n_ce,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] checksum
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_VERIFY = 3'd2,
        S_RUN    = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t     state_r;
    logic [3:0] ptr_r;
    logic [7:0] checksum_r;
    logic [3:0] addr_r;
    logic [7:0] din_r;
    logic       prog_r;
    logic       n_ce_r;
    logic       in_ready_r;
    logic       busy_r;
    logic       done_r;
    logic       accept_s;
    logic       cpu_owns_s;

`ifdef RAMCTL_VERIFY_EN
    logic [4:0] v_r;
    logic [7:0] rsum_r;
    logic [7:0] rsum_next_s;
    logic       error_r;

    assign rsum_next_s = rsum_r + ram_dout;
`else
    logic       unused_dout_s;

    assign unused_dout_s = ^ram_dout;
`endif

    assign accept_s = in_valid & in_ready_r;
    // The CPU takes the bus only once the trailing write of the last byte has finished.
    assign cpu_owns_s = (state_r == S_RUN) && !prog_r;

    // Controller state, load pointer, checksum and registered RAM-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            ptr_r      <= 4'd0;
            checksum_r <= 8'd0;
            addr_r     <= 4'd0;
            din_r      <= 8'd0;
            prog_r     <= 1'b0;
            n_ce_r     <= 1'b1;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
`ifdef RAMCTL_VERIFY_EN
            v_r        <= 5'd0;
            rsum_r     <= 8'd0;
            error_r    <= 1'b0;
`endif
        end else begin
            prog_r <= 1'b0;
            case (state_r)
                S_IDLE, S_RUN, S_ERROR: begin
                    if (load_start) begin
                        state_r    <= S_LOAD;
                        ptr_r      <= 4'd0;
                        checksum_r <= 8'd0;
                        addr_r     <= 4'd0;
                        n_ce_r     <= 1'b1;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                        done_r     <= 1'b0;
`ifdef RAMCTL_VERIFY_EN
                        error_r    <= 1'b0;
`endif
                    end else begin
                        state_r <= state_r;
                    end
                end
                S_LOAD: begin
                    if (accept_s) begin
                        addr_r     <= ptr_r;
                        din_r      <= in_data;
                        prog_r     <= 1'b1;
                        ptr_r      <= ptr_r + 4'd1;
                        checksum_r <= checksum_r + in_data;
                        if (ptr_r == 4'd15) begin
                            in_ready_r <= 1'b0;
`ifdef RAMCTL_VERIFY_EN
                            state_r    <= S_VERIFY;
                            v_r        <= 5'd0;
                            rsum_r     <= 8'd0;
                            n_ce_r     <= 1'b0;
`else
                            state_r    <= S_RUN;
                            busy_r     <= 1'b0;
                            done_r     <= 1'b1;
`endif
                        end else begin
                            state_r <= S_LOAD;
                        end
                    end else begin
                        state_r <= S_LOAD;
                    end
                end
`ifdef RAMCTL_VERIFY_EN
                S_VERIFY: begin
                    v_r <= v_r + 5'd1;
                    if (v_r <= 5'd15) begin
                        addr_r <= v_r[3:0];
                    end else begin
                        addr_r <= addr_r;
                    end
                    if (v_r >= 5'd2) begin
                        rsum_r <= rsum_next_s;
                    end else begin
                        rsum_r <= rsum_r;
                    end
                    // Final read lands at v=17; compare including that last byte.
                    if (v_r == 5'd17) begin
                        busy_r <= 1'b0;
                        n_ce_r <= 1'b1;
                        addr_r <= 4'd0;
                        if (rsum_next_s == checksum_r) begin
                            state_r <= S_RUN;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= S_ERROR;
                            error_r <= 1'b1;
                        end
                    end else begin
                        state_r <= S_VERIFY;
                    end
                end
`endif
                default: begin
                    state_r    <= S_IDLE;
                    in_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                    n_ce_r     <= 1'b1;
                    addr_r     <= 4'd0;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_r;
    assign ram_addr      = cpu_owns_s ? cpu_addr : addr_r;
    assign ram_n_ce      = cpu_owns_s ? cpu_n_ce : n_ce_r;
    assign ram_din       = din_r;
    assign ram_prog_mode = prog_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign checksum      = checksum_r;
`ifdef RAMCTL_VERIFY_EN
    assign error         = error_r;
`else
    assign error         = 1'b0;
`endif

endmodule

// File: tb/tb_ram_loader_ctrl.sv
// Randomized bench for ram_loader_ctrl with a behavioural RAM and an image/checksum reference model.
// Expectations for the verify path follow RAMCTL_VERIFY_EN.
module tb_ram_loader_ctrl;

    logic       clk;
    logic       rst;
    logic       load_start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [3:0] cpu_addr;
    logic       cpu_n_ce;
    logic [7:0] ram_dout;
    logic [3:0] ram_addr;
    logic [7:0] ram_din;
    logic       ram_prog_mode;
    logic       ram_n_ce;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] checksum;

    int tests_run;
    int tests_failed;
    int cyc;

    logic [7:0] mem     [16];
    logic [7:0] img     [16];
    logic [7:0] exp_mem [16];
    logic       corrupt7;
    int         wr_addr_q [$];
    int         wr_data_q [$];
    int         wr_cyc_q  [$];

`ifdef RAMCTL_VERIFY_EN
    localparam int HAND_LAT = 18;
`else
    localparam int HAND_LAT = 0;
`endif

    ram_loader_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .load_start   (load_start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .cpu_addr     (cpu_addr),
        .cpu_n_ce     (cpu_n_ce),
        .ram_dout     (ram_dout),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .ram_prog_mode(ram_prog_mode),
        .ram_n_ce     (ram_n_ce),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .checksum     (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM: writes on negedge while prog_mode is high, registered read on posedge.
    always @(negedge clk) begin
        if (ram_prog_mode === 1'b1) begin
            mem[ram_addr] <= ram_din;
            wr_addr_q.push_back(int'(ram_addr));
            wr_data_q.push_back(int'(ram_din));
            wr_cyc_q.push_back(cyc);
        end
    end

    always @(posedge clk) begin
        if (ram_n_ce === 1'b0)
            ram_dout <= mem[ram_addr] ^ ((corrupt7 && ram_addr == 4'd7) ? 8'h01 : 8'h00);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] img_sum();
        int s = 0;
        for (int i = 0; i < 16; i++) s += int'(img[i]);
        return 8'(s % 256);
    endfunction

    // mode 0: full rate, 1: valid every other cycle, 2: random stalls and ignored load_start pulses
    task automatic do_load(input int mode, input int n_bytes);
        int  idx;
        int  guard;
        logic v;
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        load_start = 1'b1;
        in_valid   = 1'b1;
        in_data    = img[0] ^ 8'h5A;
        @(posedge clk); #1;
        load_start = 1'b0;
        in_valid   = 1'b0;
        check_val("in_ready_rise", in_ready, 1);
        check_val("busy_load", busy, 1);
        check_val("done_clr", done, 0);
        check_val("error_clr", error, 0);
        check_val("cksum_clr", checksum, 0);
        idx = 0;
        guard = 0;
        while (idx < n_bytes && guard < 400) begin
            check_val("in_ready_load", in_ready, 1);
            check_val("n_ce_load", ram_n_ce, 1);
            case (mode)
                0:       v = 1'b1;
                1:       v = (guard % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            in_valid   = v;
            in_data    = v ? img[idx] : 8'($urandom);
            load_start = (mode == 2) && ($urandom_range(0, 7) == 0);
            @(posedge clk); #1;
            if (v) idx++;
            guard++;
        end
        in_valid   = 1'b0;
        load_start = 1'b0;
        if (idx < n_bytes) check_val("load_timeout", idx, n_bytes);
    endtask

    task automatic run_load(input int mode, input logic exp_err);
        int n;
        logic [7:0] s;
        s = img_sum();
        do_load(mode, 16);
        check_val("in_ready_after", in_ready, 0);
        n = 0;
        while (done !== 1'b1 && error !== 1'b1 && n < 40) begin
            check_val("busy_verify", busy, 1);
            @(posedge clk); #1;
            n++;
        end
        check_val("handover_lat", n, HAND_LAT);
        check_val("done_end", done, !exp_err);
        check_val("error_end", error, exp_err);
        check_val("busy_end", busy, 0);
        check_val("checksum", checksum, s);
        @(negedge clk); #1;
        check_val("wr_count", wr_addr_q.size(), 16);
        for (int i = 0; i < 16 && i < wr_addr_q.size(); i++) begin
            check_val("wr_addr", wr_addr_q[i], i);
            check_val("wr_data", wr_data_q[i], img[i]);
            if (i > 0 && mode < 2) check_val("wr_spacing", wr_cyc_q[i] - wr_cyc_q[i-1], mode + 1);
        end
        for (int i = 0; i < 16; i++) exp_mem[i] = img[i];
        for (int i = 0; i < 16; i++) check_val("mem_img", mem[i], exp_mem[i]);
        @(posedge clk); #1;
        check_val("prog_idle", ram_prog_mode, 0);
        check_val("checksum_hold", checksum, s);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        cyc = 0;
        corrupt7 = 1'b0;
        rst = 1'b1;
        load_start = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        cpu_addr = 4'd0;
        cpu_n_ce = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_ram_addr", ram_addr, 0);
        check_val("rst_ram_din", ram_din, 0);
        check_val("rst_prog", ram_prog_mode, 0);
        check_val("rst_n_ce", ram_n_ce, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_error", error, 0);
        check_val("rst_checksum", checksum, 0);

        // Ascending image at full rate.
        for (int i = 0; i < 16; i++) img[i] = 8'(i);
        run_load(0, 1'b0);
        check_val("checksum_78", checksum, 8'h78);

        // CPU ownership in RUN.
        cpu_addr = 4'd9;
        cpu_n_ce = 1'b0;
        #1;
        check_val("run_addr9", ram_addr, 9);
        check_val("run_nce0", ram_n_ce, 0);
        check_val("run_prog", ram_prog_mode, 0);
        for (int k = 0; k < 4; k++) begin
            cpu_addr = 4'($urandom);
            cpu_n_ce = 1'($urandom);
            #1;
            check_val("run_addr", ram_addr, cpu_addr);
            check_val("run_nce", ram_n_ce, cpu_n_ce);
            @(posedge clk); #1;
            check_val("run_prog_k", ram_prog_mode, 0);
            check_val("run_done", done, 1);
        end
        cpu_n_ce = 1'b1;
        cpu_addr = 4'd0;

        // All-ones image with every other cycle stalled.
        for (int i = 0; i < 16; i++) img[i] = 8'hFF;
        run_load(1, 1'b0);
        check_val("checksum_f0", checksum, 8'hF0);

`ifdef RAMCTL_VERIFY_EN
        // Corrupted read-back of address 7 must end in a sticky error.
        corrupt7 = 1'b1;
        for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
        run_load(0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_val("error_sticky", error, 1);
        check_val("error_n_ce", ram_n_ce, 1);
        check_val("error_addr", ram_addr, 0);
        corrupt7 = 1'b0;
        for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
        run_load(2, 1'b0);
`endif

        // Random images with random stalls.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
            run_load(2, 1'b0);
        end

        // Reset after the 5th accepted byte.
        for (int i = 0; i < 16; i++) img[i] = exp_mem[i] ^ 8'($urandom_range(1, 255));
        do_load(0, 5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("mid_rst_in_ready", in_ready, 0);
        check_val("mid_rst_prog", ram_prog_mode, 0);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_done", done, 0);
        check_val("mid_rst_checksum", checksum, 0);
        repeat (3) @(negedge clk);
        #1;
        check_val("mid_rst_wr_count", wr_addr_q.size(), 5);
        for (int i = 0; i < 5; i++) exp_mem[i] = img[i];
        for (int i = 0; i < 16; i++) check_val("mid_rst_mem", mem[i], exp_mem[i]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
